// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_pkg
// Description : Shared definitions for the fetch stage.
//               - RV32 base opcode constants
//               - PCSrc next-PC select encodings
//               - fetch FSM state encoding
//               - fault cause codes
//               - misalignment helper
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

  // Base opcodes, as seen by the main controller on inst[6:0]
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Next-PC select (PCSrc); the reserved code behaves as PC_PLUS4
  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;
  localparam logic [1:0] PC_RSVD  = 2'b11;

  // Fault cause codes
  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b01;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b10;

  // Fetch FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  // Instruction addresses must be word aligned
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return |addr_lsb;
  endfunction

endpackage : fetch_unit_pkg
`default_nettype wire

// File: rtl/fetch_next_pc.sv
`default_nettype none
// ============================================================================
// Module      : fetch_next_pc
// Description : Combinational next-PC selection and alignment check.
// Ports       : pc_i          current PC
//               pc_src_i      PCSrc select (PC_PLUS4/PC_IMM/PC_ALU/PC_RSVD)
//               imm_ext_i     sign-extended immediate
//               alu_result_i  jalr target from the ALU
//               pc_plus4_o    pc_i + 4 (link value)
//               npc_o         selected next PC
//               misaligned_o  npc_o is not word aligned
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_next_pc
  import fetch_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic [1:0]      pc_src_i,
  input  logic [XLEN-1:0] imm_ext_i,
  input  logic [XLEN-1:0] alu_result_i,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic [XLEN-1:0] npc_o,
  output logic            misaligned_o
);

  // All additions wrap modulo 2^XLEN; that wrap is architecturally legal.
  assign pc_plus4_o = pc_i + XLEN'(4);

  always_comb begin
    npc_o = pc_plus4_o;
    case (pc_src_i)
      PC_IMM:  npc_o = pc_i + imm_ext_i;
      // jalr clears bit 0 of the target; bit 1 is still checked below
      PC_ALU:  npc_o = alu_result_i & ~XLEN'(1);
      default: npc_o = pc_plus4_o;
    endcase
  end

  assign misaligned_o = is_misaligned(npc_o[1:0]);

endmodule : fetch_next_pc
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch and PC sequencing stage. Holds PC and IR,
//               issues one instruction-memory read at a time (req/rvalid),
//               presents the instruction until exec_done, then advances PC
//               according to PCSrc. Fetch timeout and misaligned next-PC
//               raise a sticky fault that only rst clears.
// Ports       : clk, rst                      clock / async active-high reset
//               imem_req/addr/rvalid/rdata    instruction memory handshake
//               exec_done, PCSrc, imm_ext,    commit and next-PC selection
//               alu_result
//               inst, opcode, f3, f7          IR and decoded fields
//               pc, pc_plus4                  PC of IR and its link value
//               inst_valid                    IR awaits exec_done
//               retired                       committed-instruction count
//               fault, fault_cause            sticky fault status
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 16
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            exec_done,
  input  logic [1:0]      PCSrc,
  input  logic [XLEN-1:0] imm_ext,
  input  logic [XLEN-1:0] alu_result,
  output logic [31:0]     inst,
  output logic [6:0]      opcode,
  output logic [2:0]      f3,
  output logic [6:0]      f7,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            inst_valid,
  output logic [31:0]     retired,
  output logic            fault,
  output logic [1:0]      fault_cause
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     inst_q;
  logic            inst_valid_q;
  logic            imem_req_q;
  logic [31:0]     retired_q;
  logic            fault_q;
  logic [1:0]      fault_cause_q;
  logic [CW-1:0]   cnt_q;

  logic [XLEN-1:0] npc_d;
  logic            npc_misaligned_d;

  fetch_next_pc #(
    .XLEN (XLEN)
  ) u_next_pc (
    .pc_i         (pc_q),
    .pc_src_i     (PCSrc),
    .imm_ext_i    (imm_ext),
    .alu_result_i (alu_result),
    .pc_plus4_o   (pc_plus4),
    .npc_o        (npc_d),
    .misaligned_o (npc_misaligned_d)
  );

  // Single-process FSM; every output is a register. imem_req_q is set on
  // every transition into FETCH and cleared on every exit, so it equals
  // (state == FETCH) without a decode glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      inst_q        <= 32'h0;
      inst_valid_q  <= 1'b0;
      imem_req_q    <= 1'b0;
      retired_q     <= 32'h0;
      fault_q       <= 1'b0;
      fault_cause_q <= CAUSE_NONE;
      cnt_q         <= '0;
    end else begin
      case (state_q)
        // Any rvalid seen here belongs to a request aborted by reset.
        ST_IDLE: begin
          state_q    <= ST_FETCH;
          imem_req_q <= 1'b1;
          cnt_q      <= '0;
        end

        ST_FETCH: begin
          if (imem_rvalid) begin
            inst_q       <= imem_rdata;
            inst_valid_q <= 1'b1;
            imem_req_q   <= 1'b0;
            cnt_q        <= '0;
            state_q      <= ST_ISSUE;
          end else if (cnt_q == CNT_LAST) begin
            // TIMEOUT consecutive FETCH cycles without a response
            fault_q       <= 1'b1;
            fault_cause_q <= CAUSE_TIMEOUT;
            imem_req_q    <= 1'b0;
            state_q       <= ST_FAULT;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        ST_ISSUE: begin
          if (exec_done) begin
            // The instruction completed, so it counts even if the
            // target it produced is unusable.
            retired_q    <= retired_q + 32'd1;
            inst_valid_q <= 1'b0;
            if (npc_misaligned_d) begin
              fault_q       <= 1'b1;
              fault_cause_q <= CAUSE_MISALIGN;
              state_q       <= ST_FAULT;
            end else begin
              pc_q       <= npc_d;
              imem_req_q <= 1'b1;
              cnt_q      <= '0;
              state_q    <= ST_FETCH;
            end
          end
        end

        ST_FAULT: begin
          imem_req_q   <= 1'b0;
          inst_valid_q <= 1'b0;
        end

        default: begin
          state_q    <= ST_FAULT;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign inst        = inst_q;
  assign opcode      = inst_q[6:0];
  assign f3          = inst_q[14:12];
  assign f7          = inst_q[31:25];
  assign inst_valid  = inst_valid_q;
  assign retired     = retired_q;
  assign fault       = fault_q;
  assign fault_cause = fault_cause_q;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. A table of instructions
//               with hand-computed PCs walks the next-PC paths (including
//               wrap and a jalr misalignment fault), followed by directed
//               sequences for reset, stale responses, timeout and exec_done
//               outside ISSUE.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam int TIMEOUT = 4;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        exec_done;
  logic [1:0]  PCSrc;
  logic [31:0] imm_ext;
  logic [31:0] alu_result;
  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        inst_valid;
  logic [31:0] retired;
  logic        fault;
  logic [1:0]  fault_cause;

  fetch_unit #(
    .XLEN     (32),
    .RESET_PC (32'h0),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .exec_done   (exec_done),
    .PCSrc       (PCSrc),
    .imm_ext     (imm_ext),
    .alu_result  (alu_result),
    .inst        (inst),
    .opcode      (opcode),
    .f3          (f3),
    .f7          (f7),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .inst_valid  (inst_valid),
    .retired     (retired),
    .fault       (fault),
    .fault_cause (fault_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Bounded wait for imem_req; always evaluated at a falling edge.
  task automatic wait_req();
    int k;
    k = 0;
    while (imem_req !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("req_seen", {31'b0, imem_req}, 32'd1);
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    imem_rvalid = 1'b0;
    exec_done   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Answer the pending request after lat empty FETCH cycles.
  task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] word, input int lat);
    wait_req();
    chk("fetch_addr", imem_addr, exp_addr);
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      chk("req_held", {31'b0, imem_req}, 32'd1);
      chk("addr_stable", imem_addr, exp_addr);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    chk("inst_valid_set", {31'b0, inst_valid}, 32'd1);
    chk("inst", inst, word);
    chk("req_dropped", {31'b0, imem_req}, 32'd0);
    chk("no_fault", {31'b0, fault}, 32'd0);
  endtask

  task automatic do_commit(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] alu);
    PCSrc      = src;
    imm_ext    = imm;
    alu_result = alu;
    exec_done  = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  src;
    logic [31:0] imm;
    logic [31:0] alu;
    logic [31:0] word;
    int          lat;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        flt;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    // src, imm, alu, word, lat, pc, npc, fault
    tbl[0] = '{2'b00, 32'h0000_0055, 32'h0000_0999, 32'h0000_0013, 0, 32'h0000_0000, 32'h0000_0004, 1'b0};
    tbl[1] = '{2'b00, 32'h1234_5678, 32'h0000_0002, 32'h00A5_8593, 1, 32'h0000_0004, 32'h0000_0008, 1'b0};
    tbl[2] = '{2'b11, 32'h0000_0040, 32'h0000_0080, 32'h40B5_0533, 2, 32'h0000_0008, 32'h0000_000C, 1'b0};
    tbl[3] = '{2'b01, 32'h0000_0004, 32'h0000_0333, 32'h0041_4663, 0, 32'h0000_000C, 32'h0000_0010, 1'b0};
    tbl[4] = '{2'b01, 32'hFFFF_FFF8, 32'h0000_0444, 32'hFE00_0CE3, TIMEOUT-1, 32'h0000_0010, 32'h0000_0008, 1'b0};
    tbl[5] = '{2'b10, 32'h0000_0020, 32'h0000_0105, 32'h0000_80E7, 1, 32'h0000_0008, 32'h0000_0104, 1'b0};
    tbl[6] = '{2'b10, 32'h0000_0000, 32'hFFFF_FFFD, 32'h0040_C0E7, 0, 32'h0000_0104, 32'hFFFF_FFFC, 1'b0};
    tbl[7] = '{2'b00, 32'h0000_0010, 32'h0000_0010, 32'h0000_006F, 2, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0};
    tbl[8] = '{2'b01, 32'h0000_0100, 32'h0000_0001, 32'h1000_006F, 0, 32'h0000_0000, 32'h0000_0100, 1'b0};
    tbl[9] = '{2'b10, 32'h0000_0004, 32'h0000_0106, 32'h0000_0067, 1, 32'h0000_0100, 32'h0000_0100, 1'b1};

    rst         = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    exec_done   = 1'b0;
    PCSrc       = 2'b00;
    imm_ext     = 32'h0;
    alu_result  = 32'h0;

    // ---------------- reset state ----------------
    @(negedge clk);
    @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_retired", retired, 32'h0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_cause", {30'b0, fault_cause}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_to_fetch_req", {31'b0, imem_req}, 32'd1);

    // ---------------- table-driven instruction stream ----------------
    for (int i = 0; i < 10; i++) begin
      do_fetch(tbl[i].pc, tbl[i].word, tbl[i].lat);
      chk("pc", pc, tbl[i].pc);
      chk("pc_plus4", pc_plus4, tbl[i].pc + 32'd4);
      chk("opcode", {25'b0, opcode}, {25'b0, tbl[i].word[6:0]});
      chk("f3", {29'b0, f3}, {29'b0, tbl[i].word[14:12]});
      chk("f7", {25'b0, f7}, {25'b0, tbl[i].word[31:25]});
      @(negedge clk);
      chk("inst_held", inst, tbl[i].word);
      chk("req_low_in_issue", {31'b0, imem_req}, 32'd0);
      do_commit(tbl[i].src, tbl[i].imm, tbl[i].alu);
      chk("retired", retired, 32'(i + 1));
      chk("inst_valid_clr", {31'b0, inst_valid}, 32'd0);
      if (!tbl[i].flt) begin
        chk("next_req", {31'b0, imem_req}, 32'd1);
        chk("next_addr", imem_addr, tbl[i].npc);
        chk("fault_clear", {31'b0, fault}, 32'd0);
      end else begin
        chk("mis_fault", {31'b0, fault}, 32'd1);
        chk("mis_cause", {30'b0, fault_cause}, 32'd2);
        chk("mis_pc_holds", pc, tbl[i].pc);
        chk("mis_req", {31'b0, imem_req}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("mis_sticky", {31'b0, fault}, 32'd1);
        chk("mis_req_stays_low", {31'b0, imem_req}, 32'd0);
        chk("mis_pc_still", pc, tbl[i].pc);
      end
    end

    // ---------------- misaligned immediate target ----------------
    do_reset();
    do_fetch(32'h0, 32'h0020_0063, 1);
    do_commit(2'b01, 32'h0000_0002, 32'h0);
    chk("imm_mis_fault", {31'b0, fault}, 32'd1);
    chk("imm_mis_cause", {30'b0, fault_cause}, 32'd2);
    chk("imm_mis_pc", pc, 32'h0);
    chk("imm_mis_retired", retired, 32'd1);

    // ---------------- exec_done outside ISSUE, concurrent signals, reset in FETCH ----------------
    do_reset();
    chk("rst_clears_fault", {31'b0, fault}, 32'd0);
    do_fetch(32'h0, 32'h0000_0013, 0);
    do_commit(2'b00, 32'h0, 32'h0);
    chk("seq_addr4", imem_addr, 32'h4);
    // exec_done while fetching must not move pc or count
    PCSrc     = 2'b01;
    imm_ext   = 32'h0000_0040;
    exec_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("fetch_ed_pc", pc, 32'h4);
    chk("fetch_ed_retired", retired, 32'd1);
    chk("fetch_ed_req", {31'b0, imem_req}, 32'd1);
    // rvalid and exec_done together in FETCH: only the response acts
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h00C0_0093;
    @(negedge clk);
    exec_done   = 1'b0;
    chk("both_inst", inst, 32'h00C0_0093);
    chk("both_valid", {31'b0, inst_valid}, 32'd1);
    chk("both_retired", retired, 32'd1);
    chk("both_pc", pc, 32'h4);
    // rvalid during ISSUE must not overwrite the IR
    imem_rdata = 32'hBAD0_0BAD;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("issue_rvalid_ignored", inst, 32'h00C0_0093);
    do_commit(2'b00, 32'h0, 32'h0);
    chk("seq_addr8", imem_addr, 32'h8);
    chk("seq_retired2", retired, 32'd2);
    // asynchronous reset mid-fetch, then a stale response during IDLE
    rst = 1'b1;
    #1;
    chk("async_pc", pc, 32'h0);
    chk("async_req", {31'b0, imem_req}, 32'd0);
    chk("async_retired", retired, 32'd0);
    chk("async_inst", inst, 32'h0);
    @(negedge clk);
    rst         = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    chk("stale_inst", inst, 32'h0);
    chk("stale_valid", {31'b0, inst_valid}, 32'd0);
    chk("stale_req", {31'b0, imem_req}, 32'd1);
    chk("stale_addr", imem_addr, 32'h0);
    @(negedge clk);
    chk("stale_still_waiting", {31'b0, inst_valid}, 32'd0);
    do_fetch(32'h0, 32'h0010_0093, 0);

    // ---------------- fetch timeout ----------------
    do_reset();
    wait_req();
    chk("to_fault_start", {31'b0, fault}, 32'd0);
    for (int k = 1; k < TIMEOUT; k++) begin
      @(negedge clk);
      chk("to_req_held", {31'b0, imem_req}, 32'd1);
      chk("to_no_fault_yet", {31'b0, fault}, 32'd0);
    end
    @(negedge clk);
    chk("to_fault", {31'b0, fault}, 32'd1);
    chk("to_cause", {30'b0, fault_cause}, 32'd1);
    chk("to_req_low", {31'b0, imem_req}, 32'd0);
    chk("to_pc", pc, 32'h0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0013;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("to_late_rvalid_valid", {31'b0, inst_valid}, 32'd0);
    chk("to_late_rvalid_inst", inst, 32'h0);
    chk("to_sticky", {31'b0, fault}, 32'd1);
    rst = 1'b1;
    #1;
    chk("to_rst_fault", {31'b0, fault}, 32'd0);
    chk("to_rst_cause", {30'b0, fault_cause}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("to_restart_req", {31'b0, imem_req}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_fetch_unit
`default_nettype wire
